// File: rtl/conv_cfg_pkg.sv
// Shared constants, response codes and write-FSM state type for the
// convolution configuration register file.
package conv_cfg_pkg;

  localparam int NUM_TAPS = 9;

  // Word offsets (byte address >> 2)
  localparam logic [3:0] WORD_CTRL    = 4'd0;
  localparam logic [3:0] WORD_STATUS  = 4'd1;
  localparam logic [3:0] WORD_SHIFT   = 4'd2;
  localparam logic [3:0] WORD_KERNEL0 = 4'd3;
  localparam logic [3:0] WORD_LIMIT   = 4'd12;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_ADDR,
    W_WAIT_DATA,
    W_RESP
  } wr_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_axil_cfg_slave_if.sv
// AXI4-Lite bus bundle for the convolution configuration slave.
interface conv_axil_cfg_slave_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/conv_axil_wr_fsm.sv
// AW/W/B handshake engine: accepts address and data in either order and
// presents a single-cycle commit with the merged address/data/strobe.
module conv_axil_wr_fsm
  import conv_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic                  wr_mapped_i,
  output logic                  commit_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [31:0]           data_o,
  output logic [3:0]            strb_o
);

  wr_state_e             state_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [3:0]            strb_q;
  logic                  aw_hs;
  logic                  w_hs;

  assign aw_hs = awvalid_i & awready_q;
  assign w_hs  = wvalid_i & wready_q;

  // Whichever half arrived first comes from the latch, the other from the bus
  always_comb begin
    addr_o   = (state_q == W_WAIT_DATA) ? addr_q : awaddr_i;
    data_o   = (state_q == W_WAIT_ADDR) ? data_q : wdata_i;
    strb_o   = (state_q == W_WAIT_ADDR) ? strb_q : wstrb_i;
    commit_o = ((state_q == W_IDLE) && aw_hs && w_hs) ||
               ((state_q == W_WAIT_DATA) && w_hs) ||
               ((state_q == W_WAIT_ADDR) && aw_hs);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else if (commit_o) begin
      state_q   <= W_RESP;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_mapped_i ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (state_q)
        W_IDLE: begin
          if (aw_hs) begin
            addr_q    <= awaddr_i;
            state_q   <= W_WAIT_DATA;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs) begin
            data_q    <= wdata_i;
            strb_q    <= wstrb_i;
            state_q   <= W_WAIT_ADDR;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_WAIT_ADDR, W_WAIT_DATA: ;
        W_RESP: begin
          if (bready_i) begin
            bvalid_q  <= 1'b0;
            state_q   <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;

endmodule

// File: rtl/conv_axil_cfg_slave.sv
// AXI4-Lite register file exposing control, status, shift and 3x3 kernel
// coefficients to the convolution datapath.
module conv_axil_cfg_slave
  import conv_cfg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int COEFF_WIDTH        = 8
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  conv_axil_cfg_slave_if.slave              s_axi,
  input  logic                              status_busy,
  input  logic [15:0]                       status_frame_cnt,
  output logic                              ctrl_enable,
  output logic                              ctrl_bypass,
  output logic                              soft_clear,
  output logic [3:0]                        out_shift,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0]   kernel_coeffs,
  output logic                              cfg_update
);

  localparam int WW = C_S_AXI_ADDR_WIDTH - 2;

  logic                          wr_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]                   wr_data;
  logic [3:0]                    wr_strb;
  logic [WW-1:0]                 wr_word;
  logic                          wr_mapped;
  logic [WW-1:0]                 rd_word;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
  logic [1:0]                    rd_resp;

  logic [1:0]             ctrl_q;
  logic [3:0]             shift_q;
  logic [COEFF_WIDTH-1:0] kern_q [NUM_TAPS];
  logic                   soft_clear_q;
  logic                   cfg_update_q;
  logic                   arready_q;
  logic                   rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]             rresp_q;

  logic [31:0]          ctrl_merged;
  logic [31:0]          shift_merged;
  logic [31:0]          tap_merged [NUM_TAPS];
  logic [31:0]          tap_rd     [NUM_TAPS];
  logic [NUM_TAPS-1:0]  unused_tap;
  logic                 unused_bits;

  assign wr_word   = wr_addr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_mapped = (wr_word < WORD_LIMIT);
  assign rd_word   = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

  conv_axil_wr_fsm #(.ADDR_WIDTH(C_S_AXI_ADDR_WIDTH)) u_wr_fsm (
    .clk         (ACLK),
    .rst         (ARESET),
    .awaddr_i    (s_axi.awaddr),
    .awvalid_i   (s_axi.awvalid),
    .awready_o   (s_axi.awready),
    .wdata_i     (s_axi.wdata),
    .wstrb_i     (s_axi.wstrb),
    .wvalid_i    (s_axi.wvalid),
    .wready_o    (s_axi.wready),
    .bresp_o     (s_axi.bresp),
    .bvalid_o    (s_axi.bvalid),
    .bready_i    (s_axi.bready),
    .wr_mapped_i (wr_mapped),
    .commit_o    (wr_commit),
    .addr_o      (wr_addr),
    .data_o      (wr_data),
    .strb_o      (wr_strb)
  );

  // Bit 2 of the CTRL merge is the write-1 soft-clear request, never stored
  assign ctrl_merged  = apply_strb({30'b0, ctrl_q}, wr_data, wr_strb);
  assign shift_merged = apply_strb({28'b0, shift_q}, wr_data, wr_strb);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      assign tap_merged[gi] = apply_strb({{(32-COEFF_WIDTH){1'b0}}, kern_q[gi]}, wr_data, wr_strb);
      assign tap_rd[gi]     = {{(32-COEFF_WIDTH){kern_q[gi][COEFF_WIDTH-1]}}, kern_q[gi]};
      assign kernel_coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] = kern_q[gi];
      assign unused_tap[gi] = ^tap_merged[gi][31:COEFF_WIDTH];
    end
  endgenerate

  assign unused_bits = ^{unused_tap, ctrl_merged[31:3], shift_merged[31:4],
                         s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_q       <= '0;
      shift_q      <= '0;
      soft_clear_q <= 1'b0;
      cfg_update_q <= 1'b0;
      for (int t = 0; t < NUM_TAPS; t++) kern_q[t] <= '0;
    end else begin
      soft_clear_q <= 1'b0;
      cfg_update_q <= 1'b0;
      if (wr_commit) begin
        if (wr_word == WORD_CTRL) begin
          ctrl_q       <= ctrl_merged[1:0];
          soft_clear_q <= ctrl_merged[2];
        end
        if (wr_word == WORD_SHIFT) begin
          shift_q      <= shift_merged[3:0];
          cfg_update_q <= 1'b1;
        end
        for (int t = 0; t < NUM_TAPS; t++) begin
          if (wr_word == WORD_KERNEL0 + 4'(t)) begin
            kern_q[t]    <= tap_merged[t][COEFF_WIDTH-1:0];
            cfg_update_q <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (rd_word == WORD_CTRL) begin
      rd_data = {30'b0, ctrl_q};
    end else if (rd_word == WORD_STATUS) begin
      rd_data = {status_frame_cnt, 15'b0, status_busy};
    end else if (rd_word == WORD_SHIFT) begin
      rd_data = {28'b0, shift_q};
    end else if (rd_word >= WORD_LIMIT) begin
      rd_resp = RESP_SLVERR;
    end else begin
      for (int t = 0; t < NUM_TAPS; t++) begin
        if (rd_word == WORD_KERNEL0 + 4'(t)) rd_data = tap_rd[t];
      end
    end
  end

  // Read data is captured at the AR handshake, so a same-cycle write is not visible
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (rvalid_q) begin
      if (s_axi.rready) begin
        rvalid_q  <= 1'b0;
        arready_q <= 1'b1;
      end
    end else if (s_axi.arvalid && arready_q) begin
      rvalid_q  <= 1'b1;
      arready_q <= 1'b0;
      rdata_q   <= rd_data;
      rresp_q   <= rd_resp;
    end else begin
      arready_q <= 1'b1;
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign ctrl_enable = ctrl_q[0];
  assign ctrl_bypass = ctrl_q[1];
  assign out_shift   = shift_q;
  assign soft_clear  = soft_clear_q;
  assign cfg_update  = cfg_update_q;

endmodule
